// File: rtl/stack_arb_pkg.sv
// stack_arb_pkg: shared FSM state encoding and push/pop opcodes for the stack arbiter
package stack_arb_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_RD, DONE} state_t;
  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; last_grant moves only when a grant is taken
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic last_grant;
  always_comb grant = &req ? (last_grant ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_grant <= 1'b1;
    else if (advance && |req) last_grant <= grant[1];
endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: stack pointer owner sequencing a single-port stack RAM for two
// requesters with round-robin arbitration and full/empty error reporting
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  r0_req,
  input  logic                  r0_op,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_ack,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_err,
  input  logic                  r1_req,
  input  logic                  r1_op,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_ack,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH-1:0] sp,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  state_t state, next;
  logic [ADDR_WIDTH:0] count;
  logic [1:0] grant;
  logic gid, err_q, start, op_in, bad;
  logic [DATA_WIDTH-1:0] wdata_q, result, hold0, hold1;

  rr_arb2 u_arb (.clk(clk), .rst(rst), .req({r1_req, r0_req}), .advance(start), .grant(grant));

  assign full  = count == (ADDR_WIDTH + 1)'(DEPTH);
  assign empty = count == '0;
  assign sp    = count[ADDR_WIDTH-1:0];
  assign start = state == IDLE && !clear && (r0_req || r1_req);
  assign op_in = grant[1] ? r1_op : r0_op;
  assign bad   = op_in == OP_PUSH ? full : empty;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = bad ? DONE : (op_in == OP_POP ? READ : WRITE);
      WRITE:   next = DONE;
      READ:    next = WAIT_RD;
      WAIT_RD: next = DONE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    ram_we    = state == WRITE;
    ram_re    = state == READ;
    ram_addr  = ram_we ? sp : (ram_re ? sp - 1'b1 : '0);
    ram_wdata = ram_we ? wdata_q : '0;
    r0_ack    = state == DONE && !gid;
    r1_ack    = state == DONE && gid;
    r0_err    = r0_ack && err_q;
    r1_err    = r1_ack && err_q;
    r0_rdata  = r0_ack ? result : hold0;
    r1_rdata  = r1_ack ? result : hold1;
  end

  // result is zeroed at grant so push and error acks never return stale pop data
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count   <= '0;
      gid     <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      result  <= '0;
      hold0   <= '0;
      hold1   <= '0;
    end else begin
      if (state == IDLE && clear) count <= '0;
      if (start) begin
        gid     <= grant[1];
        err_q   <= bad;
        wdata_q <= grant[1] ? r1_wdata : r0_wdata;
        result  <= '0;
      end
      if (state == WRITE) count <= count + 1'b1;
      if (state == READ) count <= count - 1'b1;
      if (state == WAIT_RD) result <= ram_rdata;
      if (r0_ack) hold0 <= result;
      if (r1_ack) hold1 <= result;
    end
endmodule
